// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 magnitude datapath: shift-add multiply and restoring divide, one bit per step.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   rem_o
);

    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    // Multiply: {high accumulator, multiplier}. Divide: low half is dividend/quotient.
    logic [2*XLEN-1:0] prod_q, prod_d;
    // The settled remainder always fits XLEN bits; the XLEN+1-bit partial lives in rem_sh.
    logic [XLEN-1:0]   rem_q, rem_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   diff;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
        rem_sh  = {rem_q, prod_q[XLEN-1]};
        diff    = {1'b0, rem_sh} - {2'b00, b_q};
        if (load_i) begin
            a_d    = a_i;
            b_d    = b_i;
            prod_d = is_div_i ? {{XLEN{1'b0}}, a_i} : {{XLEN{1'b0}}, b_i};
            rem_d  = '0;
        end else if (step_i) begin
            if (is_div_i) begin
                if (!diff[XLEN+1]) begin
                    rem_d              = diff[XLEN-1:0];
                    prod_d[XLEN-1:0]   = {prod_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d              = rem_sh[XLEN-1:0];
                    prod_d[XLEN-1:0]   = {prod_q[XLEN-2:0], 1'b0};
                end
            end else if (prod_q[0]) begin
                prod_d = {mul_sum, prod_q[XLEN-1:1]};
            end else begin
                prod_d = {1'b0, prod_q[2*XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            rem_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            rem_q  <= rem_d;
        end
    end

    assign prod_o = prod_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide controller: stalls execute, runs XLEN radix-2 steps,
// then fixes signs and issues a one-cycle writeback.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            flush_in,
    input  logic [6:0]      opcode_in,
    input  logic [2:0]      funct3_in,
    input  logic [6:0]      funct7_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic [4:0]      rd_in,
    output logic            stall_out,
    output logic            busy_out,
    output logic            rd_write,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result_out
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic [4:0]        rd_q, rd_out_q;
    logic [XLEN-1:0]   result_q;

    logic              start, load, step, special, is_signed_div, is_rem;
    logic              sign_a, sign_b, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
    logic [2*XLEN-1:0] prod, prod_adj;
    logic [XLEN-1:0]   rem, rem_adj;

    assign start = valid_in && opcode_in == OPC_OP && funct7_in == F7_MULDIV &&
                   state_q == IDLE && !flush_in;

    // Operand signedness and the final sign fix are decided once, at capture time.
    always_comb begin
        is_signed_div = funct3_in == F3_DIV || funct3_in == F3_REM;
        is_rem        = funct3_in == F3_REM || funct3_in == F3_REMU;
        sign_a = rs1_value_in[XLEN-1] &&
                 (funct3_in == F3_MULH || funct3_in == F3_MULHSU || is_signed_div);
        sign_b = rs2_value_in[XLEN-1] && (funct3_in == F3_MULH || is_signed_div);
        a_mag  = sign_a ? -rs1_value_in : rs1_value_in;
        b_mag  = sign_b ? -rs2_value_in : rs2_value_in;
        neg_d  = is_rem ? sign_a : (sign_a ^ sign_b);
    end

    // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (funct3_in[2]) begin
            if (rs2_value_in == '0) begin
                special     = 1'b1;
                special_res = is_rem ? rs1_value_in : '1;
            end else if (is_signed_div && rs1_value_in == INT_MIN && rs2_value_in == '1) begin
                special     = 1'b1;
                special_res = is_rem ? '0 : INT_MIN;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = !special;
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (flush_in)                          state_d = IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))    state_d = FIX;
            end
            FIX:     state_d = flush_in ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Negating the full product keeps the high half correct for signed MULH/MULHSU.
    always_comb begin
        prod_adj = neg_q ? -prod : prod;
        rem_adj  = neg_q ? -rem : rem;
        case (f3_q)
            F3_MUL:                        fix_res = prod_adj[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_adj[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_res = prod_adj[XLEN-1:0];
            default:                       fix_res = rem_adj;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q <= '0;
                f3_q  <= funct3_in;
                neg_q <= neg_d;
                rd_q  <= rd_in;
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (start && special) begin
                result_q <= special_res;
                rd_out_q <= rd_in;
            end else if (state_q == FIX && !flush_in) begin
                result_q <= fix_res;
                rd_out_q <= rd_q;
            end
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (f3_q[2] & ~load | funct3_in[2] & load),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .prod_o   (prod),
        .rem_o    (rem)
    );

    assign stall_out  = start || state_q == CALC || state_q == FIX;
    assign busy_out   = state_q != IDLE;
    assign rd_write   = state_q == DONE;
    assign rd_out     = rd_out_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed table, random ops against an arithmetic model,
// plus flush, reset and non-M corner sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, flush_in;
    logic [6:0]  opcode_in, funct7_in;
    logic [2:0]  funct3_in;
    logic [31:0] rs1_value_in, rs2_value_in;
    logic [4:0]  rd_in;
    logic        stall_out, busy_out, rd_write;
    logic [4:0]  rd_out;
    logic [31:0] result_out;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .flush_in     (flush_in),
        .opcode_in    (opcode_in),
        .funct3_in    (funct3_in),
        .funct7_in    (funct7_in),
        .rs1_value_in (rs1_value_in),
        .rs2_value_in (rs2_value_in),
        .rd_in        (rd_in),
        .stall_out    (stall_out),
        .busy_out     (busy_out),
        .rd_write     (rd_write),
        .rd_out       (rd_out),
        .result_out   (result_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference result from RISC-V M semantics using wide host arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        bit stall_ok;
        lat = -1;
        stall_ok = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b1; opcode_in = 7'b0110011; funct7_in = 7'b0000001;
        funct3_in = f3; rs1_value_in = a; rs2_value_in = b; rd_in = rd;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rd_write) begin lat = c; break; end
            if (!stall_out) stall_ok = 1'b0;
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
        valid_in = 1'b0;
        chk({nm, " latency"}, lat, exp_lat);
        if (lat >= 0) begin
            chk({nm, " result"}, result_out, exp);
            chk({nm, " rd"}, {27'd0, rd_out}, {27'd0, rd});
            chk({nm, " stall held"}, {31'd0, stall_ok}, 32'd1);
            chk({nm, " stall in done"}, {31'd0, stall_out}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          wr_seen;

        vt[0]  = '{"MUL 7*-3",      3'd0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vt[1]  = '{"MULHU -1*-1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vt[2]  = '{"MULH -1*-1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
        vt[3]  = '{"MULHSU -1*2",   3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 34};
        vt[4]  = '{"DIV -7/2",      3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34};
        vt[5]  = '{"REM -7/2",      3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34};
        vt[6]  = '{"DIVU 100/7",    3'd5, 32'd100,       32'd7,         32'd14,        34};
        vt[7]  = '{"REMU 100/7",    3'd7, 32'd100,       32'd7,         32'd2,         34};
        vt[8]  = '{"DIV x/0",       3'd4, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1};
        vt[9]  = '{"REM x/0",       3'd6, 32'h1234,      32'h0,         32'h1234,      1};
        vt[10] = '{"DIV ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vt[11] = '{"REM ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        vt[12] = '{"DIVU x/0",      3'd5, 32'h55,        32'h0,         32'hFFFF_FFFF, 1};
        vt[13] = '{"MUL hi bits",   3'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_0000 + 32'hF, 34};

        rst_n = 1'b0; valid_in = 1'b0; flush_in = 1'b0;
        opcode_in = '0; funct3_in = '0; funct7_in = '0;
        rs1_value_in = '0; rs2_value_in = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {31'd0, stall_out}, 32'd0);
        chk("reset busy", {31'd0, busy_out}, 32'd0);
        chk("reset rd_write", {31'd0, rd_write}, 32'd0);
        chk("reset rd_out", {27'd0, rd_out}, 32'd0);
        chk("reset result", result_out, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(vt[i].nm, vt[i].f3, vt[i].a, vt[i].b, 5'(i + 5), vt[i].exp, vt[i].lat);

        // result/rd hold after the writeback
        held = result_out;
        repeat (3) @(negedge clk);
        chk("result hold", result_out, held);

        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op("random", rf3, ra, rb, 5'($urandom), ref_res(rf3, ra, rb), ref_lat(rf3, ra, rb));
        end

        // flush at cycle 10 of a DIV
        held = result_out;
        @(posedge clk); #1;
        valid_in = 1'b1; opcode_in = 7'b0110011; funct7_in = 7'b0000001;
        funct3_in = 3'd4; rs1_value_in = 32'd1000; rs2_value_in = 32'd3; rd_in = 5'd9;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
        flush_in = 1'b1;
        @(negedge clk);
        chk("flush busy before", {31'd0, busy_out}, 32'd1);
        @(posedge clk); #1;
        flush_in = 1'b0;
        @(negedge clk);
        chk("flush busy after", {31'd0, busy_out}, 32'd0);
        wr_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_write) wr_seen++;
        end
        chk("flush no writeback", wr_seen, 0);
        chk("flush result kept", result_out, held);
        run_op("MUL 3*4 after flush", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 34);

        // flush beats start in the same cycle
        @(posedge clk); #1;
        valid_in = 1'b1; flush_in = 1'b1; funct3_in = 3'd0;
        @(negedge clk);
        chk("flush vs start stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0; flush_in = 1'b0;
        @(negedge clk);
        chk("flush vs start busy", {31'd0, busy_out}, 32'd0);

        // async reset at cycle 20 of a MUL
        @(posedge clk); #1;
        valid_in = 1'b1; funct3_in = 3'd0; rs1_value_in = 32'd9; rs2_value_in = 32'd9; rd_in = 5'd3;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
        chk("pre-reset busy", {31'd0, busy_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy_out}, 32'd0);
        chk("async rst stall", {31'd0, stall_out}, 32'd0);
        chk("async rst rd_write", {31'd0, rd_write}, 32'd0);
        chk("async rst rd_out", {27'd0, rd_out}, 32'd0);
        chk("async rst result", result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD never engages the sequencer
        @(posedge clk); #1;
        valid_in = 1'b1; opcode_in = 7'b0110011; funct7_in = 7'b0000000;
        funct3_in = 3'd0; rs1_value_in = 32'd5; rs2_value_in = 32'd6; rd_in = 5'd7;
        wr_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_write || stall_out || busy_out) wr_seen++;
        end
        valid_in = 1'b0;
        chk("ADD ignored", wr_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide controller that sits beside the execute-stage ALU.
- Detects M-extension instructions (opcode 0110011, funct7 0000001), captures operands, and sequences a radix-2 shift-add/shift-subtract datapath.
- Holds the pipeline through stall_out until the result is ready, then delivers a single-cycle writeback pulse in the same format as execute (rd_out, rd_write, result_out).

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_in  in  1  execute-stage instruction valid.
- flush_in  in  1  abort the in-flight operation (branch/trap).
- opcode_in  in  7  instruction opcode.
- funct3_in  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- funct7_in  in  7  instruction funct7.
- rs1_value_in  in  XLEN  operand A.
- rs2_value_in  in  XLEN  operand B.
- rd_in  in  5  destination register.
- stall_out  out  1  hold upstream stages and execute.
- busy_out  out  1  FSM not in IDLE.
- rd_write  out  1  one-cycle writeback strobe.
- rd_out  out  5  captured rd.
- result_out  out  XLEN  final result.

Behaviour:
Reset: state=IDLE and all outputs 0. The counter, accumulator and operand registers are also 0.

Start condition:
- start = valid_in & opcode_in==0110011 & funct7_in==0000001 & state==IDLE & !flush_in.

stall_out (combinational):
- Equals start | state∈{CALC, FIX}.
- Low in IDLE without start, and low in DONE, so the pipeline advances exactly on the DONE cycle.

FSM (IDLE, CALC, FIX, DONE):
- IDLE→CALC on start, with these captures:
  - funct3, rd_in, and |A|, |B| per signedness: MULH signs both, MULHSU signs A only, DIV/REM sign both, others unsigned.
  - neg_res = sign-adjust flag: for MUL*, signA^signB; for DIV, signA^signB; for REM, signA.
  - counter=0 and accumulator=0.
- IDLE→DONE directly (special cases, no CALC) on start:
  - Divide by zero (rs2==0): DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow for DIV/REM (rs1==0x8000_0000, rs2==0xFFFF_FFFF): DIV result = 0x8000_0000; REM result = 0.
- CALC runs one iteration per cycle, then increments counter.
  - Multiply: 2*XLEN product register, shift-add on the LSB of the multiplier.
  - Divide: restoring shift-subtract, building the quotient and the XLEN+1-bit remainder.
  - CALC→FIX when counter==XLEN-1.
- FIX takes one cycle:
  - Apply two's-complement negation when neg_res is set.
  - Select the result: MUL → low half; MULH/MULHSU/MULHU → high half; DIV/DIVU → quotient; REM/REMU → remainder.
  - Register the result into result_out. FIX→DONE.
- DONE takes one cycle: rd_write=1 and rd_out=captured rd. DONE→IDLE.

Latency:
- Normal path: start at cycle 0 → rd_write at cycle XLEN+2 (34).
- Special case: start at cycle 0 → rd_write at cycle 1.

rd_write: high only in DONE. result_out and rd_out hold their values until the next DONE.

flush_in:
- In CALC or FIX: next state IDLE, rd_write is never asserted, result_out is unchanged.
- In DONE: ignored, because the writeback belongs to an older committed instruction.
- Flush has priority over start in the same cycle.

Non-M instructions: never start the FSM; stall_out stays low.

Asynchronous reset mid-operation: immediately returns to IDLE with outputs 0; no writeback.

Arithmetic: all internal arithmetic is unsigned on magnitudes; the sign is applied only in FIX. There is no wrap-around beyond XLEN except the documented overflow case.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum {IDLE, CALC, FIX, DONE};
  - the funct3 constants (F3_MUL … F3_REMU);
  - OPC_OP=7'b0110011 and F7_MULDIV=7'b0000001.
- Sub-module muldiv_datapath holds the operand, product/quotient and remainder registers and the per-iteration step logic. The sequencer FSM, counter and special-case detection stay in muldiv_sequencer.

Test Plan:
- MUL 7 × -3 (0x7, 0xFFFF_FFFD), rd=5 → stall_out high for cycles 0–33; rd_write at cycle 34 with rd_out=5 and result_out=0xFFFF_FFEB.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → result_out=0xFFFF_FFFE. MULH of the same operands → 0x0000_0000. MULHSU 0xFFFF_FFFF × 2 → 0xFFFF_FFFF.
- DIV -7 / 2 → 0xFFFF_FFFD. REM -7 / 2 → 0xFFFF_FFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV x/0 with rs1=0x1234 → rd_write at cycle 1 with result 0xFFFF_FFFF; REM x/0 → 0x1234. DIV 0x8000_0000 / -1 → 0x8000_0000 at cycle 1; REM of the same → 0.
- flush_in asserted at cycle 10 of a DIV → busy_out low at cycle 11; no rd_write pulse; the next MUL 3 × 4 completes with result 12.
- rst_n dropped at cycle 20 of a MUL → all outputs 0 asynchronously. An ADD (funct7=0000000) presented afterwards → stall_out stays 0 and no rd_write occurs.
